// File: rtl/param_das_beamformer.sv
// -----------------------------------------------------------------------------
// param_das_beamformer
//
// Parametrised delay-and-sum beamformer. A frame is captured into one sample
// RAM per channel, then every output point k is formed as
//   y[k] = sum over enabled channels of x_ch[k + delay[ch]]
// and stored in an output RAM that the host reads once the frame is done.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start, abort  frame start (IDLE/DONE only) and return-to-IDLE pulses
//   in_valid      capture strobe for in_data (lane ch at [ch*DATA_W +: DATA_W])
//   dly_we/ch/val per-channel delay write port (IDLE/DONE only)
//   ch_mask       channel enables, taken on the first compute cycle
//   out_rd_en     output RAM read strobe, out_rd_addr selects the point
//   out_rd_data   registered read data, one cycle latency
//   busy          high while capturing or computing
//   done          high once a frame has been fully computed
// -----------------------------------------------------------------------------
module param_das_beamformer #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 11,
  parameter int OUT_LEN = 540,
  parameter int OUT_AW  = 10,
  parameter int DELAY_W = 11,
  parameter int ACC_W   = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     dly_we,
  input  logic [3:0]               dly_ch,
  input  logic [DELAY_W-1:0]       dly_val,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     out_rd_en,
  input  logic [OUT_AW-1:0]        out_rd_addr,
  output logic [ACC_W-1:0]         out_rd_data,
  output logic                     busy,
  output logic                     done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int SUM_W = DELAY_W + 1;
  localparam int CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [OUT_AW-1:0] LAST_K  = OUT_AW'(OUT_LEN - 1);
  localparam logic [CH_IW-1:0]  LAST_CH = CH_IW'(NUM_CH - 1);

  logic [1:0]          state;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [DELAY_W-1:0]  delay_r [NUM_CH];
  logic [DATA_W-1:0]   sample_mem [NUM_CH][DEPTH];
  logic [ACC_W-1:0]    out_mem [OUT_LEN];

  logic                issuing;
  logic [OUT_AW-1:0]   k_cnt;
  logic [CH_IW-1:0]    ch_cnt;
  logic [NUM_CH-1:0]   mask_q;

  logic                s1_valid;
  logic                s1_first;
  logic                s1_last;
  logic                s1_en;
  logic [OUT_AW-1:0]   s1_k;
  logic [DATA_W-1:0]   rd_q;

  logic [ACC_W-1:0]    acc;
  logic                wr_pend;
  logic [OUT_AW-1:0]   wr_k;

  logic                capture_last;
  logic                entry_cycle;
  logic [NUM_CH-1:0]   eff_mask;
  logic [SUM_W-1:0]    rd_addr_full;
  logic                in_range;
  logic [ACC_W-1:0]    term;
  logic [ACC_W-1:0]    acc_next;

  assign busy = (state == ST_CAPTURE) || (state == ST_COMPUTE);
  assign done = (state == ST_DONE);

  // The final capture write is the one landing on the top RAM address.
  assign capture_last = (state == ST_CAPTURE) && in_valid && (&wr_cnt);

  // The mask is live on the first compute cycle and held from then on, so the
  // very first read already sees the value presented at compute entry.
  assign entry_cycle = issuing && (k_cnt == '0) && (ch_cnt == '0);
  assign eff_mask    = entry_cycle ? ch_mask : mask_q;

  // Read address is one bit wider than the delay so k + delay never wraps;
  // anything past the captured depth contributes nothing.
  assign rd_addr_full = SUM_W'(k_cnt) + SUM_W'(delay_r[ch_cnt]);
  assign in_range     = (32'(rd_addr_full) < 32'(DEPTH));

  // Main control: abort beats start, capture runs until the top address is
  // written, compute ends once the last output point has been stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      wr_cnt <= '0;
    end else if (abort) begin
      state  <= ST_IDLE;
      wr_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_CAPTURE;
            wr_cnt <= '0;
          end
        end
        ST_CAPTURE: begin
          if (in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (&wr_cnt) state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (wr_pend && (wr_k == LAST_K)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Delay registers can only change while no frame is in flight; channel
  // selects beyond the instantiated count simply match nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) delay_r[c] <= '0;
    end else if (dly_we && !busy) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (dly_ch == 4'(c)) delay_r[c] <= dly_val;
      end
    end
  end

  // Sample RAMs: all lanes are written together during capture, and during
  // compute a single channel is read per cycle into rd_q.
  always_ff @(posedge clk) begin
    if ((state == ST_CAPTURE) && in_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sample_mem[c][wr_cnt] <= in_data[c*DATA_W +: DATA_W];
      end
    end
    if ((state == ST_COMPUTE) && issuing) begin
      rd_q <= sample_mem[ch_cnt][rd_addr_full[ADDR_W-1:0]];
    end
  end

  // Read-issue sequencer: walks channels inside output indices and stops
  // after the last channel of the last point. Armed by the final capture write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issuing <= 1'b0;
      k_cnt   <= '0;
      ch_cnt  <= '0;
      mask_q  <= '0;
    end else if (abort || (state != ST_COMPUTE)) begin
      issuing <= capture_last && !abort;
      k_cnt   <= '0;
      ch_cnt  <= '0;
    end else if (issuing) begin
      if (entry_cycle) mask_q <= ch_mask;
      if (ch_cnt == LAST_CH) begin
        ch_cnt <= '0;
        if (k_cnt == LAST_K) issuing <= 1'b0;
        else                 k_cnt   <= k_cnt + 1'b1;
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // Tags that travel alongside the RAM read so the accumulator knows, when
  // the data arrives, whether to use it and where the point starts and ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_en    <= 1'b0;
      s1_k     <= '0;
    end else if (abort || (state != ST_COMPUTE)) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= issuing;
      s1_first <= (ch_cnt == '0);
      s1_last  <= (ch_cnt == LAST_CH);
      s1_en    <= in_range && eff_mask[ch_cnt];
      s1_k     <= k_cnt;
    end
  end

  // Sign-extended term, restarting the sum on each point's first channel.
  always_comb begin
    term = '0;
    if (s1_en) term = ACC_W'($signed(rd_q));
    acc_next = (s1_first ? '0 : acc) + term;
  end

  // Accumulator; a completed point is flagged for storage on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      wr_pend <= 1'b0;
      wr_k    <= '0;
    end else if (abort || (state != ST_COMPUTE)) begin
      wr_pend <= 1'b0;
    end else begin
      wr_pend <= s1_valid && s1_last;
      if (s1_valid) begin
        acc  <= acc_next;
        wr_k <= s1_k;
      end
    end
  end

  // Output RAM store; contents survive aborts and resets.
  always_ff @(posedge clk) begin
    if ((state == ST_COMPUTE) && wr_pend) out_mem[wr_k] <= acc;
  end

  // Host read port: zero while a frame is in flight or beyond the frame length,
  // otherwise the stored point. Holds its value when not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_rd_data <= '0;
    end else if (out_rd_en) begin
      if (busy || (32'(out_rd_addr) >= 32'(OUT_LEN))) out_rd_data <= '0;
      else                                           out_rd_data <= out_mem[out_rd_addr];
    end
  end

endmodule

// File: tb/tb_param_das_beamformer.sv
// -----------------------------------------------------------------------------
// tb_param_das_beamformer
//
// Drives whole frames into param_das_beamformer and compares every output
// point against a reference that evaluates the delay-and-sum formula directly
// on the stored input samples, delays and mask.
// -----------------------------------------------------------------------------
module tb_param_das_beamformer;

  localparam int NCH   = 3;
  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int DEPTH = 2 ** AW;
  localparam int OL    = 540;
  localparam int OAW   = 10;
  localparam int DLW   = 11;
  localparam int ACCW  = 36;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic               in_valid;
  logic [NCH*DW-1:0]  in_data;
  logic               dly_we;
  logic [3:0]         dly_ch;
  logic [DLW-1:0]     dly_val;
  logic [NCH-1:0]     ch_mask;
  logic               out_rd_en;
  logic [OAW-1:0]     out_rd_addr;
  logic [ACCW-1:0]    out_rd_data;
  logic               busy;
  logic               done;

  int compared;
  int mismatched;

  // Reference state: captured samples, delays and mask as the host set them.
  int               xs [NCH][DEPTH];
  int               dly_m [NCH];
  logic [NCH-1:0]   mask_m;

  logic [ACCW-1:0]  rd_val;
  logic [NCH-1:0]   rmask;

  param_das_beamformer #(
    .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .OUT_LEN(OL),
    .OUT_AW(OAW), .DELAY_W(DLW), .ACC_W(ACCW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data),
    .dly_we(dly_we), .dly_ch(dly_ch), .dly_val(dly_val),
    .ch_mask(ch_mask),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
    .busy(busy), .done(done)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Direct evaluation of y[k]: enabled channels, read index k+delay, nothing
  // contributed past the captured depth, wrapped to the output width.
  function automatic logic [ACCW-1:0] model_y(input int k);
    longint s = 0;
    for (int c = 0; c < NCH; c++) begin
      if (mask_m[c]) begin
        longint a = longint'(k) + longint'(dly_m[c]);
        if (a < DEPTH) s += longint'(xs[c][a]);
      end
    end
    return ACCW'(s);
  endfunction

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host-side delay write; the model follows only when the write should land.
  task automatic write_delay(input int ch, input int val, input bit accept);
    @(negedge clk);
    dly_we  = 1'b1;
    dly_ch  = 4'(ch);
    dly_val = DLW'(val);
    @(negedge clk);
    dly_we = 1'b0;
    if (accept && ch < NCH) dly_m[ch] = val;
  endtask

  // Single output-RAM read, returned one cycle later.
  task automatic read_one(input int addr, output logic [ACCW-1:0] d);
    @(negedge clk);
    out_rd_en   = 1'b1;
    out_rd_addr = OAW'(addr);
    @(negedge clk);
    out_rd_en = 1'b0;
    d = out_rd_data;
  endtask

  // Reads the whole frame back and compares each point, plus the zero return
  // for addresses beyond the frame and the hold behaviour of the read port.
  task automatic checkFrame(input string name);
    logic [ACCW-1:0] d;
    checkOutput({name, "_done"}, 64'(done), 64'(1));
    for (int k = 0; k < OL; k++) begin
      read_one(k, d);
      checkOutput($sformatf("%s_y[%0d]", name, k), 64'(d), 64'(model_y(k)));
    end
    read_one(OL + 3, d);
    checkOutput({name, "_oob"}, 64'(d), 64'(0));
    read_one(1, d);
    @(negedge clk);
    out_rd_addr = OAW'(2);
    @(negedge clk);
    checkOutput({name, "_hold"}, 64'(out_rd_data), 64'(model_y(1)));
  endtask

  // Runs one frame: start (with a stray sample that must be dropped), a full
  // capture, then waits for done. Optional hooks: reset during capture, abort
  // during compute, and host accesses while the block is busy.
  task automatic applyStimulus(input logic [NCH-1:0] mask, input int abort_at,
                               input int reset_at, input bit poke_busy,
                               input bit check_lat);
    int cnt;
    @(negedge clk);
    ch_mask  = mask;
    mask_m   = mask;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom};
    for (int n = 0; n < DEPTH; n++) begin
      @(negedge clk);
      start     = 1'b0;
      dly_we    = 1'b0;
      out_rd_en = 1'b0;
      if (n == reset_at) begin
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_rd", 64'(out_rd_data), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) dly_m[c] = 0;
        return;
      end
      if (n == 10) checkOutput("busy_cap", 64'(busy), 64'(1));
      if (poke_busy && n == 100) begin
        dly_we      = 1'b1;
        dly_ch      = 4'd0;
        dly_val     = DLW'(777);
        out_rd_en   = 1'b1;
        out_rd_addr = OAW'(1);
      end
      if (poke_busy && n == 101) checkOutput("busy_rd", 64'(out_rd_data), 64'(0));
      in_valid = 1'b1;
      for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = xs[c][n];
    end
    @(negedge clk);
    in_valid = 1'b0;
    dly_we   = 1'b0;
    cnt = 0;
    while (cnt < OL * NCH + 50) begin
      if (cnt == abort_at) begin
        checkOutput("busy_cmp", 64'(busy), 64'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        return;
      end
      if (poke_busy && cnt == 50) begin
        dly_we  = 1'b1;
        dly_ch  = 4'd1;
        dly_val = DLW'(333);
      end
      @(negedge clk);
      dly_we = 1'b0;
      cnt++;
      if (done) break;
    end
    // Compute starts right after the final capture edge; the last point is
    // stored in compute cycle OL*NCH+1 and done shows up on the edge after.
    checkOutput("done_seen", 64'(done), 64'(1));
    if (check_lat) checkOutput("latency", 64'(cnt), 64'(OL * NCH + 2));
  endtask

  task automatic fill_random();
    for (int c = 0; c < NCH; c++)
      for (int n = 0; n < DEPTH; n++) xs[c][n] = int'($urandom);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    dly_we = 1'b0; dly_ch = '0; dly_val = '0; ch_mask = '0;
    out_rd_en = 1'b0; out_rd_addr = '0;
    for (int c = 0; c < NCH; c++) dly_m[c] = 0;
    mask_m = '0;

    #12;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_rd", 64'(out_rd_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] ramp frame, zero delays, all channels");
    for (int c = 0; c < NCH; c++)
      for (int n = 0; n < DEPTH; n++) xs[c][n] = n + c;
    applyStimulus(3'b111, -1, -1, 1'b0, 1'b1);
    checkFrame("ramp");
    read_one(7, rd_val);
    checkOutput("ramp_y7", 64'(rd_val), 64'(24));

    $display("[TB] constant input with staggered delays");
    for (int c = 0; c < NCH; c++)
      for (int n = 0; n < DEPTH; n++) xs[c][n] = 1;
    write_delay(0, 0, 1'b1);
    write_delay(1, 5, 1'b1);
    write_delay(2, 10, 1'b1);
    applyStimulus(3'b111, -1, -1, 1'b0, 1'b0);
    checkFrame("const");
    write_delay(2, 2040, 1'b1);
    applyStimulus(3'b111, -1, -1, 1'b0, 1'b0);
    checkFrame("edge");
    read_one(7, rd_val);
    checkOutput("edge_y7", 64'(rd_val), 64'(3));
    read_one(8, rd_val);
    checkOutput("edge_y8", 64'(rd_val), 64'(2));

    $display("[TB] single negative channel");
    fill_random();
    for (int n = 0; n < DEPTH; n++) xs[1][n] = -n;
    for (int c = 0; c < NCH; c++) write_delay(c, 0, 1'b1);
    applyStimulus(3'b010, -1, -1, 1'b0, 1'b0);
    checkFrame("neg");
    read_one(5, rd_val);
    checkOutput("neg_y5", 64'(rd_val), 64'(36'hFFFFFFFFB));

    $display("[TB] abort mid-compute then restart");
    fill_random();
    for (int c = 0; c < NCH; c++) write_delay(c, int'($urandom_range(0, 2047)), 1'b1);
    rmask = NCH'($urandom_range(1, 7));
    applyStimulus(rmask, 100, -1, 1'b0, 1'b0);
    fill_random();
    rmask = NCH'($urandom_range(1, 7));
    applyStimulus(rmask, -1, -1, 1'b0, 1'b0);
    checkFrame("restart");

    $display("[TB] host accesses while busy");
    write_delay(5, 123, 1'b1);
    read_one(1, rd_val);
    checkOutput("pre_busy_rd", 64'(rd_val), 64'(model_y(1)));
    fill_random();
    write_delay(0, 40, 1'b1);
    write_delay(1, 0, 1'b1);
    applyStimulus(3'b111, -1, -1, 1'b1, 1'b0);
    checkFrame("busywr");

    $display("[TB] reset during capture");
    for (int c = 0; c < NCH; c++) write_delay(c, int'($urandom_range(1, 2047)), 1'b1);
    fill_random();
    applyStimulus(3'b111, -1, 500, 1'b0, 1'b0);
    fill_random();
    applyStimulus(3'b111, -1, -1, 1'b0, 1'b0);
    checkFrame("postrst");

    $display("[TB] random frame");
    fill_random();
    for (int c = 0; c < NCH; c++) write_delay(c, int'($urandom_range(0, 2047)), 1'b1);
    rmask = NCH'($urandom_range(0, 7));
    applyStimulus(rmask, -1, -1, 1'b0, 1'b0);
    checkFrame("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
